serial_alu_ctrl: RTL and testbench

Sequencer that runs one 1-bit ALU slice over WIDTH cycles, LSB first, to produce a full WIDTH-bit result.
- Latches operands and opcode on an input valid/ready handshake.
- Shifts one bit per cycle through the slice and chains the carry in a register.
- Presents result and flags on an output valid/ready handshake.
- Sits between the issue logic and the writeback path. It is the area-minimal ALU option.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_bit_slice.sv | 36 +++
 rtl/serial_alu_ctrl.sv | 136 +++++++++++++
 tb/tb_serial_alu_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, controller state encoding and opcode classification helpers
// for the bit-serial ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_NOR);
  endfunction

  function automatic logic is_arith_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational one-bit ALU slice; SUB is ADD of the inverted B bit with the
// carry chain seeded to 1 by the controller.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_cin,
  input  logic [3:0] i_op,
  output logic       o_bit,
  output logic       o_cout
);

  logic w_b_eff;

  always_comb begin
    o_bit   = 1'b0;
    o_cout  = 1'b0;
    w_b_eff = i_b;
    case (i_op)
      OP_AND: o_bit = i_a & i_b;
      OP_OR:  o_bit = i_a | i_b;
      OP_NOR: o_bit = ~(i_a | i_b);
      OP_ADD, OP_SUB: begin
        w_b_eff = (i_op == OP_SUB) ? ~i_b : i_b;
        o_bit   = i_a ^ w_b_eff ^ i_cin;
        o_cout  = (i_a & w_b_eff) | (i_a & i_cin) | (w_b_eff & i_cin);
      end
      default: begin
        o_bit  = 1'b0;
        o_cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: latches an operation, runs one slice over WIDTH
// cycles LSB first, then presents the registered result and flags.
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             illegal,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Producers hold valid and payload stable until that edge; ready may be
  // asserted independently of valid. in_ready is high only in IDLE and
  // out_valid only in DONE, so the two never overlap in one cycle.

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_illegal;

  logic             w_bit;
  logic             w_slice_cout;
  logic             w_accept;
  logic             w_release;
  logic             w_last;
  logic             w_arith;
  logic             w_legal;
  logic [WIDTH-1:0] w_res_final;

  alu_bit_slice u_slice (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_cin  (r_carry),
    .i_op   (r_op),
    .o_bit  (w_bit),
    .o_cout (w_slice_cout)
  );

  assign w_accept    = in_valid && (r_state == IDLE);
  assign w_release   = out_ready && (r_state == DONE);
  assign w_last      = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_arith     = is_arith_op(r_op);
  assign w_legal     = is_legal_op(r_op);
  assign w_res_final = {w_bit, r_res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (w_release) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr    <= '0;
      r_b_sr    <= '0;
      r_res_sr  <= '0;
      r_result  <= '0;
      r_op      <= OP_AND;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_op     <= op;
      r_res_sr <= '0;
      r_cnt    <= '0;
      r_carry  <= (op == OP_SUB);
    end else if (r_state == RUN) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_res_sr <= w_res_final;
      r_carry  <= w_arith ? w_slice_cout : 1'b0;
      if (!w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        // r_carry here is the carry into the MSB, so overflow is cin ^ cout.
        r_result  <= w_legal ? w_res_final : '0;
        r_cout    <= w_arith & w_slice_cout;
        r_ovf     <= w_arith & (r_carry ^ w_slice_cout);
        r_zero    <= !w_legal || (w_res_final == '0);
        r_illegal <= !w_legal;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign illegal   = r_illegal;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl with hand-computed expectations.
module tb_serial_alu_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             illegal;
  logic [1:0]       dbg_state;

  int n_vec  = 0;
  int n_fail = 0;

  serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts an op at a negedge; returns at the negedge where out_valid rose,
  // with k = negedges after the accept edge (9 expected for WIDTH=8).
  task automatic start_and_wait(input logic [3:0] t_op, input logic [7:0] t_a,
                                input logic [7:0] t_b, input string tag);
    int k;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op = t_op;
    a  = t_a;
    b  = t_b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op = 4'($urandom_range(0, 15));
    a  = 8'($urandom_range(0, 255));
    b  = 8'($urandom_range(0, 255));
    k = 1;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, 32'd9);
    check({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_res, input logic e_cout,
                           input logic e_ovf, input logic e_zero, input logic e_ill);
    check({tag, "_result"},  {24'd0, result},   {24'd0, e_res});
    check({tag, "_cout"},    {31'd0, cout},     {31'd0, e_cout});
    check({tag, "_ovf"},     {31'd0, ovf},      {31'd0, e_ovf});
    check({tag, "_zero"},    {31'd0, zero},     {31'd0, e_zero});
    check({tag, "_illegal"}, {31'd0, illegal},  {31'd0, e_ill});
  endtask

  task automatic run_op(input logic [3:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                        input logic [7:0] e_res, input logic e_cout, input logic e_ovf,
                        input logic e_zero, input logic e_ill, input string tag);
    out_ready = 1'b1;
    start_and_wait(t_op, t_a, t_b, tag);
    check_out(tag, e_res, e_cout, e_ovf, e_zero, e_ill);
    @(negedge clk);
    check({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready_after"},  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'd0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_state",     {30'd0, dbg_state}, 32'd0);
    check_out("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, "add_7f_01");
    run_op(4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, "sub_05_05");
    run_op(4'b0110, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, "sub_00_01");
    run_op(4'b0110, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, "sub_80_01");
    run_op(4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, "and");
    run_op(4'b0001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, "or");
    run_op(4'b1100, 8'hF0, 8'h3C, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, "nor");

    // Backpressure: result held while a new request waits on in_valid.
    out_ready = 1'b0;
    start_and_wait(4'b0010, 8'hFF, 8'h01, "bp");
    in_valid = 1'b1;
    op = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      check_out("bp_hold", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready",  {31'd0, in_ready},  32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_out_valid_after", {31'd0, out_valid}, 32'd0);
    check("bp_in_ready_after",  {31'd0, in_ready},  32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_no_accept_state", {30'd0, dbg_state}, 32'd0);

    run_op(4'b0011, 8'hF0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "illegal");

    // Reset four cycles after accept must abort the operation.
    in_valid = 1'b1;
    op = 4'b0010;
    a  = 8'h11;
    b  = 8'h22;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_state_run", {30'd0, dbg_state}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_out("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_no_output", seen, 32'd0);
    check("mid_in_ready_idle", {31'd0, in_ready}, 32'd1);

    run_op(4'b0010, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, "add_12_34");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
